// File: rtl/eth_rx_filter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : eth_rx_filter_pkg
//  Description : Shared constants and helpers for the Ethernet receive filter:
//                FSM state encoding, CRC-32 constants, SFD, broadcast MAC,
//                minimum frame length and width helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package eth_rx_filter_pkg;

    // Receive FSM state encoding
    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_pre     = 3'd1;
    localparam logic [2:0] c_st_dest    = 3'd2;
    localparam logic [2:0] c_st_src     = 3'd3;
    localparam logic [2:0] c_st_type    = 3'd4;
    localparam logic [2:0] c_st_payload = 3'd5;
    localparam logic [2:0] c_st_tail    = 3'd6;
    localparam logic [2:0] c_st_ignore  = 3'd7;

    localparam logic [31:0] c_crc_poly    = 32'h04c11db7;
    localparam logic [31:0] c_crc_residue = 32'hc704dd7b;
    localparam logic [7:0]  c_sfd         = 8'hd5;
    localparam logic [47:0] c_bcast_mac   = 48'hffff_ffff_ffff;
    localparam int          c_min_frame   = 64;

    // Buffer index width; a single buffer still gets one address bit
    function automatic int buf_w(input int nbuf);
        return (nbuf > 1) ? $clog2(nbuf) : 1;
    endfunction

    function automatic int off_w(input int pb);
        return $clog2(pb);
    endfunction

    function automatic logic [31:0] bitrev32(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = x[31-i];
        return r;
    endfunction

    // One byte of the LSB-first (reflected) CRC-32 update, no final inversion
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        logic [31:0] poly_r;
        poly_r = bitrev32(c_crc_poly);
        c = crc ^ {24'h0, d};
        for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ poly_r) : (c >> 1);
        return c;
    endfunction

    // Station address byte in wire order: index 0 is bits [47:40]
    function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = mac[47:40];
            3'd1:    b = mac[39:32];
            3'd2:    b = mac[31:24];
            3'd3:    b = mac[23:16];
            3'd4:    b = mac[15:8];
            default: b = mac[7:0];
        endcase
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/eth_rx_filter_if.sv
`default_nettype none
// ============================================================================
//  Module      : eth_rx_filter_if
//  Description : Host-side bundle of the receive filter: packet RAM write
//                port plus the committed-buffer handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
interface eth_rx_filter_if #(
    parameter int NBUF          = 2,
    parameter int PAYLOAD_BYTES = 64
);
    import eth_rx_filter_pkg::*;

    localparam int BUF_W = buf_w(NBUF);
    localparam int OFF_W = off_w(PAYLOAD_BYTES);
    localparam int LEN_W = OFF_W + 1;

    logic [BUF_W+OFF_W-1:0] rx_waddr;
    logic [7:0]             rx_wdata;
    logic                   rx_we;
    logic                   rx_valid;
    logic [BUF_W-1:0]       rx_buf;
    logic [LEN_W-1:0]       rx_len;
    logic                   rx_release;

    modport master (
        output rx_waddr, rx_wdata, rx_we, rx_valid, rx_buf, rx_len,
        input  rx_release
    );

    modport slave (
        input  rx_waddr, rx_wdata, rx_we, rx_valid, rx_buf, rx_len,
        output rx_release
    );

endinterface
`default_nettype wire

// File: rtl/eth_rx_filter_crc32_d8.sv
`default_nettype none
// ============================================================================
//  Module      : crc32_d8
//  Description : Byte-wide reflected CRC-32 register. init forces all ones,
//                en folds in one byte; otherwise the state holds.
//  Revision    : 1.0 - initial release
// ============================================================================
module crc32_d8 (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        init,
    input  wire logic        en,
    input  wire logic [7:0]  data,
    output logic      [31:0] crc
);
    import eth_rx_filter_pkg::*;

    logic [31:0] r_crc;
    logic [31:0] w_crc_next;

    // Next-state: seed takes priority over a data update
    always_comb begin
        w_crc_next = r_crc;
        if (init)    w_crc_next = '1;
        else if (en) w_crc_next = crc32_byte(r_crc, data);
    end

    // CRC state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_crc <= '1;
        else        r_crc <= w_crc_next;
    end

    assign crc = r_crc;

endmodule
`default_nettype wire

// File: rtl/eth_rx_filter.sv
`default_nettype none
// ============================================================================
//  Module      : eth_rx_filter
//  Description : Ethernet receive filter. Matches destination MAC (and
//                optionally EtherType), captures the payload head into a ring
//                of packet buffers and commits a buffer only on good FCS.
//  Revision    : 1.0 - initial release
// ============================================================================
module eth_rx_filter #(
    parameter int PAYLOAD_BYTES = 64,
    parameter int NBUF          = 2,
    parameter bit ACCEPT_BCAST  = 1'b1,
    parameter bit ETYPE_FILTER  = 1'b0
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic [7:0]  data,
    input  wire logic [1:0]  ctl,
    input  wire logic [47:0] mac_addr,
    input  wire logic [15:0] etype,
    output logic      [15:0] drop_count,
    eth_rx_filter_if.master  host
);
    import eth_rx_filter_pkg::*;

    localparam int BUF_W  = buf_w(NBUF);
    localparam int OFF_W  = off_w(PAYLOAD_BYTES);
    localparam int LEN_W  = OFF_W + 1;
    localparam int PCNT_W = OFF_W + 2;
    localparam int CNT_W  = $clog2(NBUF + 1);

    logic [2:0]             r_state;
    logic [2:0]             r_cnt;
    logic                   r_uc_ok;
    logic                   r_bc_ok;
    logic [7:0]             r_type_hi;
    logic [OFF_W-1:0]       r_off;
    logic [PCNT_W-1:0]      r_pcnt;
    logic [6:0]             r_flen;
    logic                   r_idle_seen;
    logic                   r_we;
    logic [BUF_W+OFF_W-1:0] r_waddr;
    logic [7:0]             r_wdata;
    logic [BUF_W-1:0]       r_wr_ptr;
    logic [BUF_W-1:0]       r_rd_ptr;
    logic [CNT_W-1:0]       r_count;
    logic [LEN_W-1:0]       r_len [NBUF];
    logic [15:0]            r_drop;

    logic [31:0]      w_crc;
    logic             w_valid_byte;
    logic             w_in_frame;
    logic             w_uc_hit;
    logic             w_bc_hit;
    logic             w_full;
    logic             w_end;
    logic             w_commit;
    logic             w_overflow;
    logic             w_drop;
    logic             w_release;
    logic [LEN_W-1:0] w_len;
    logic [BUF_W-1:0] w_wr_next;
    logic [BUF_W-1:0] w_rd_next;

    assign w_valid_byte = (ctl == 2'b11);
    assign w_in_frame   = (r_state == c_st_dest) || (r_state == c_st_src) ||
                          (r_state == c_st_type) || (r_state == c_st_payload) ||
                          (r_state == c_st_tail);
    assign w_uc_hit     = r_uc_ok && (data == mac_byte(mac_addr, r_cnt));
    assign w_bc_hit     = ACCEPT_BCAST && r_bc_ok && (data == c_bcast_mac[7:0]);
    assign w_full       = (r_count == CNT_W'(NBUF));
    assign w_end        = w_in_frame && !w_valid_byte;
    // An error code also ends the frame, so only a clean 00 end may commit
    assign w_commit     = w_end && (ctl == 2'b00) &&
                          (w_crc == bitrev32(c_crc_residue)) &&
                          (r_flen == 7'(c_min_frame));
    assign w_overflow   = (r_state == c_st_dest) && w_valid_byte && (r_cnt == 3'd5) &&
                          (w_uc_hit || w_bc_hit) && w_full;
    // A frame cut short in DEST never matched its address, so it is not a drop
    assign w_drop       = w_overflow || (w_end && !w_commit && (r_state != c_st_dest));
    assign w_release    = host.rx_release && (r_count != '0);
    assign w_len        = (r_pcnt > PCNT_W'(4)) ? LEN_W'(r_pcnt - PCNT_W'(4)) : '0;
    assign w_wr_next    = (r_wr_ptr == BUF_W'(NBUF - 1)) ? '0 : r_wr_ptr + 1'b1;
    assign w_rd_next    = (r_rd_ptr == BUF_W'(NBUF - 1)) ? '0 : r_rd_ptr + 1'b1;

    crc32_d8 u_crc (
        .clk   (clk),
        .rst_n (rst_n),
        .init  (r_state == c_st_pre),
        .en    (w_in_frame && w_valid_byte),
        .data  (data),
        .crc   (w_crc)
    );

    // Frame parser: preamble sync, address/type filtering, payload capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_st_idle;
            r_cnt     <= '0;
            r_uc_ok   <= 1'b0;
            r_bc_ok   <= 1'b0;
            r_type_hi <= '0;
            r_off     <= '0;
            r_pcnt    <= '0;
            r_flen    <= '0;
            r_we      <= 1'b0;
            r_waddr   <= '0;
        end else begin
            r_we <= 1'b0;
            if (w_in_frame && w_valid_byte && (r_flen != 7'(c_min_frame)))
                r_flen <= r_flen + 1'b1;
            if (((r_state == c_st_payload) || (r_state == c_st_tail)) && w_valid_byte &&
                (r_pcnt != PCNT_W'(PAYLOAD_BYTES + 4)))
                r_pcnt <= r_pcnt + 1'b1;
            case (r_state)
                c_st_idle: begin
                    // Only start after a real idle gap, so a frame already in
                    // flight at reset release is not mistaken for a new one
                    if (w_valid_byte && r_idle_seen) r_state <= c_st_pre;
                end
                c_st_pre: begin
                    if (!w_valid_byte) begin
                        r_state <= c_st_idle;
                    end else if (data == c_sfd) begin
                        r_state <= c_st_dest;
                        r_cnt   <= '0;
                        r_uc_ok <= 1'b1;
                        r_bc_ok <= 1'b1;
                        r_off   <= '0;
                        r_pcnt  <= '0;
                        r_flen  <= '0;
                    end
                end
                c_st_dest: begin
                    if (!w_valid_byte) begin
                        r_state <= c_st_idle;
                    end else if (r_cnt == 3'd5) begin
                        r_cnt <= '0;
                        if (!(w_uc_hit || w_bc_hit) || w_full) r_state <= c_st_ignore;
                        else                                   r_state <= c_st_src;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                        r_uc_ok <= w_uc_hit;
                        r_bc_ok <= w_bc_hit;
                    end
                end
                c_st_src: begin
                    if (!w_valid_byte) begin
                        r_state <= c_st_idle;
                    end else if (r_cnt == 3'd5) begin
                        r_cnt   <= '0;
                        r_state <= c_st_type;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_st_type: begin
                    if (!w_valid_byte) begin
                        r_state <= c_st_idle;
                    end else if (r_cnt == 3'd0) begin
                        r_type_hi <= data;
                        r_cnt     <= 3'd1;
                    end else if (ETYPE_FILTER && ({r_type_hi, data} != etype)) begin
                        r_state <= c_st_ignore;
                    end else begin
                        r_state <= c_st_payload;
                    end
                end
                c_st_payload: begin
                    if (!w_valid_byte) begin
                        r_state <= c_st_idle;
                    end else begin
                        r_we    <= 1'b1;
                        r_waddr <= {r_wr_ptr, r_off};
                        r_off   <= r_off + 1'b1;
                        if (r_off == OFF_W'(PAYLOAD_BYTES - 1)) r_state <= c_st_tail;
                    end
                end
                c_st_tail:   if (!w_valid_byte) r_state <= c_st_idle;
                c_st_ignore: if (!w_valid_byte) r_state <= c_st_idle;
                default:     r_state <= c_st_idle;
            endcase
        end
    end

    // Write data pipeline and idle-gap tracker
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdata     <= '0;
            r_idle_seen <= 1'b0;
        end else begin
            r_wdata     <= data;
            r_idle_seen <= (ctl == 2'b00);
        end
    end

    // Buffer ring: commit advances the write side, release the read side
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < NBUF; i++) r_len[i] <= '0;
        end else begin
            if (w_commit) begin
                r_len[r_wr_ptr] <= w_len;
                r_wr_ptr        <= w_wr_next;
            end
            if (w_release) r_rd_ptr <= w_rd_next;
            case ({w_commit, w_release})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Saturating count of discarded address-matched frames
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          r_drop <= '0;
        else if (w_drop && (r_drop != '1))   r_drop <= r_drop + 1'b1;
    end

    assign host.rx_we    = r_we;
    assign host.rx_waddr = r_waddr;
    assign host.rx_wdata = r_wdata;
    assign host.rx_valid = (r_count != '0);
    assign host.rx_buf   = r_rd_ptr;
    assign host.rx_len   = r_len[r_rd_ptr];
    assign drop_count    = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_eth_rx_filter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_eth_rx_filter
//  Description : Self-checking bench for eth_rx_filter. Stimulus queues the
//                expected RAM writes; a monitor pops them as rx_we appears.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_rx_filter;

    localparam int PB    = 64;
    localparam int NB    = 2;
    localparam int BUF_W = 1;
    localparam int OFF_W = 6;
    localparam logic [47:0] MAC   = 48'h02_11_22_33_44_55;
    localparam logic [47:0] BCAST = 48'hff_ff_ff_ff_ff_ff;
    localparam logic [47:0] OTHER = 48'h02_11_22_33_44_56;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  data = 8'h00;
    logic [1:0]  ctl = 2'b00;
    logic [47:0] mac_addr = MAC;
    logic [15:0] etype = 16'h0800;
    logic [15:0] drop_count;

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0] fr[$];
    logic [BUF_W+OFF_W+7:0] exp_q[$];

    eth_rx_filter_if #(.NBUF(NB), .PAYLOAD_BYTES(PB)) host ();

    eth_rx_filter #(
        .PAYLOAD_BYTES (PB),
        .NBUF          (NB),
        .ACCEPT_BCAST  (1'b1),
        .ETYPE_FILTER  (1'b0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data       (data),
        .ctl        (ctl),
        .mac_addr   (mac_addr),
        .etype      (etype),
        .drop_count (drop_count),
        .host       (host)
    );

    always #5 clk = ~clk;

    // Write monitor: every RAM write must match the head of the scoreboard
    always @(negedge clk) begin
        logic [BUF_W+OFF_W+7:0] e;
        if (host.rx_we) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL wr_unexpected: got addr=%0d data=%02h, required no write",
                         host.rx_waddr, host.rx_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({host.rx_waddr, host.rx_wdata} !== e) begin
                    n_fail++;
                    $display("FAIL wr_data: got addr=%0d data=%02h, required addr=%0d data=%02h",
                             host.rx_waddr, host.rx_wdata, e[14:8], e[7:0]);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    task automatic tick(input logic [7:0] d, input logic [1:0] c);
        data = d;
        ctl  = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(8'h00, 2'b00);
    endtask

    // Append the IEEE 802.3 FCS (complemented reflected CRC, LSB byte first)
    task automatic add_fcs();
        logic [31:0] c;
        c = 32'hffff_ffff;
        foreach (fr[i]) begin
            c = c ^ {24'h0, fr[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hedb8_8320) : (c >> 1);
        end
        c = ~c;
        fr.push_back(c[7:0]);
        fr.push_back(c[15:8]);
        fr.push_back(c[23:16]);
        fr.push_back(c[31:24]);
    endtask

    task automatic build(input logic [47:0] dst, input int npay, input int mode);
        logic [47:0] src;
        src = 48'h02_aa_bb_cc_dd_ee;
        fr.delete();
        for (int i = 0; i < 6; i++) fr.push_back(dst[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) fr.push_back(src[47-8*i -: 8]);
        fr.push_back(8'h08);
        fr.push_back(8'h00);
        for (int i = 0; i < npay; i++) fr.push_back((mode == 0) ? 8'(i) : 8'(i * 3 + 7));
        add_fcs();
    endtask

    task automatic preamble();
        for (int i = 0; i < 7; i++) tick(8'h55, 2'b11);
        tick(8'hd5, 2'b11);
    endtask

    // Send the first nsend bytes of fr, end with endctl, then minimum IPG
    task automatic send(input bit wr, input int b, input int nsend,
                        input logic [1:0] endctl, input bit rel);
        int nwr;
        if (wr) begin
            nwr = nsend - 14;
            if (nwr < 0)  nwr = 0;
            if (nwr > PB) nwr = PB;
            for (int j = 0; j < nwr; j++) exp_q.push_back({BUF_W'(b), OFF_W'(j), fr[14+j]});
        end
        preamble();
        for (int i = 0; i < nsend; i++) tick(fr[i], 2'b11);
        host.rx_release = rel;
        tick(8'h00, endctl);
        host.rx_release = 1'b0;
        idle(12);
    endtask

    task automatic status(input string nm, input bit v, input int b, input int l, input int d);
        @(negedge clk);
        chk({nm, ".valid"}, 32'(host.rx_valid), 32'(v));
        chk({nm, ".buf"},   32'(host.rx_buf),   32'(b));
        if (v) chk({nm, ".len"}, 32'(host.rx_len), 32'(l));
        chk({nm, ".drop"},  32'(drop_count),    32'(d));
    endtask

    task automatic release_buf();
        host.rx_release = 1'b1;
        @(posedge clk);
        #1;
        host.rx_release = 1'b0;
    endtask

    initial begin
        host.rx_release = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.we",    32'(host.rx_we),    32'd0);
        chk("rst.waddr", 32'(host.rx_waddr), 32'd0);
        chk("rst.wdata", 32'(host.rx_wdata), 32'd0);
        chk("rst.valid", 32'(host.rx_valid), 32'd0);
        chk("rst.buf",   32'(host.rx_buf),   32'd0);
        chk("rst.len",   32'(host.rx_len),   32'd0);
        chk("rst.drop",  32'(drop_count),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(4);

        // Bad FCS: payload still written, then dropped
        build(MAC, 46, 0);
        fr[19] = fr[19] ^ 8'h01;
        send(1'b1, 0, fr.size(), 2'b00, 1'b0);
        status("badcrc", 1'b0, 0, 0, 1);

        // Good 46-byte payload lands in buffer 0
        build(MAC, 46, 0);
        send(1'b1, 0, fr.size(), 2'b00, 1'b0);
        status("good_a", 1'b1, 0, 46, 1);

        build(MAC, 60, 1);
        send(1'b1, 1, fr.size(), 2'b00, 1'b0);
        status("good_b", 1'b1, 0, 46, 1);

        // Ring full: ignored, counted, no writes
        build(MAC, 46, 0);
        send(1'b0, 0, fr.size(), 2'b00, 1'b0);
        status("overflow", 1'b1, 0, 46, 2);

        release_buf();
        status("rel1", 1'b1, 1, 60, 2);
        release_buf();
        status("rel2", 1'b0, 0, 0, 2);
        release_buf();
        status("rel_empty", 1'b0, 0, 0, 2);

        // Long frame: capture truncated, CRC over whole frame
        build(MAC, 1500, 0);
        send(1'b1, 0, fr.size(), 2'b00, 1'b0);
        status("long", 1'b1, 0, 64, 2);
        build(MAC, 1500, 0);
        fr[14+1499] = fr[14+1499] ^ 8'h80;
        send(1'b1, 1, fr.size(), 2'b00, 1'b0);
        status("long_bad", 1'b1, 0, 64, 3);

        // Commit and release on the same edge
        build(MAC, 50, 1);
        send(1'b1, 1, fr.size(), 2'b00, 1'b1);
        status("same_edge", 1'b1, 1, 50, 3);
        release_buf();
        status("same_edge_rel", 1'b0, 0, 0, 3);

        build(BCAST, 46, 1);
        send(1'b1, 0, fr.size(), 2'b00, 1'b0);
        status("bcast", 1'b1, 0, 46, 3);
        release_buf();

        build(OTHER, 46, 0);
        send(1'b0, 0, fr.size(), 2'b00, 1'b0);
        status("other_mac", 1'b0, 1, 0, 3);

        // Receive error mid-payload
        build(MAC, 46, 0);
        send(1'b1, 1, 34, 2'b10, 1'b0);
        status("rx_err", 1'b0, 1, 0, 4);

        // Good CRC but under 64 bytes
        build(MAC, 40, 1);
        send(1'b1, 1, fr.size(), 2'b00, 1'b0);
        status("short", 1'b0, 1, 0, 5);

        build(MAC, 46, 0);
        send(1'b0, 0, 8, 2'b00, 1'b0);
        status("runt_src", 1'b0, 1, 0, 6);
        send(1'b0, 0, 3, 2'b00, 1'b0);
        status("runt_dest", 1'b0, 1, 0, 6);

        // Reset mid-payload
        build(MAC, 46, 0);
        for (int j = 0; j < 10; j++) exp_q.push_back({BUF_W'(1), OFF_W'(j), fr[14+j]});
        preamble();
        for (int i = 0; i < 24; i++) tick(fr[i], 2'b11);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst.we",    32'(host.rx_we),    32'd0);
        chk("mid_rst.waddr", 32'(host.rx_waddr), 32'd0);
        chk("mid_rst.wdata", 32'(host.rx_wdata), 32'd0);
        chk("mid_rst.valid", 32'(host.rx_valid), 32'd0);
        chk("mid_rst.drop",  32'(drop_count),    32'd0);
        for (int i = 0; i < 3; i++) tick(8'hd5, 2'b11);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) tick(((i % 2) != 0) ? 8'hd5 : 8'h55, 2'b11);
        idle(12);
        status("post_rst", 1'b0, 0, 0, 0);

        build(MAC, 46, 0);
        send(1'b1, 0, fr.size(), 2'b00, 1'b0);
        status("resync", 1'b1, 0, 46, 0);

        idle(2);
        chk("wr_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
